// File: rtl/itcm_loader_pkg.sv
// rtl/itcm_loader_pkg.sv - shared FSM encodings, ITCM geometry and byte-lane mapping for itcm_loader
// The CHECK state exists only when ITCM_LOADER_CHECKSUM_EN is defined.
package itcm_loader_pkg;

    localparam int ITCM_DEPTH_DEFAULT = 1024;

    // Byte lanes of a little-endian 32-bit word as split across the two 16-bit banks.
    localparam int BANK0_LANE_HI = 3;
    localparam int BANK0_LANE_LO = 2;
    localparam int BANK1_LANE_HI = 1;
    localparam int BANK1_LANE_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef ITCM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [15:0] bank0_of(input logic [31:0] word);
        return {word[8*BANK0_LANE_HI +: 8], word[8*BANK0_LANE_LO +: 8]};
    endfunction

    function automatic logic [15:0] bank1_of(input logic [31:0] word);
        return {word[8*BANK1_LANE_HI +: 8], word[8*BANK1_LANE_LO +: 8]};
    endfunction

endpackage

// File: rtl/itcm_loader_byte_to_word_packer.sv
// rtl/itcm_loader_byte_to_word_packer.sv - assembles four accepted bytes into a little-endian word
// word_valid_o/word_data_o are combinational on the accepted fourth byte so the caller can register them.
module byte_to_word_packer
    import itcm_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_data_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;

    // Older bytes slide toward bit 0, so byte 0 ends up in the low lane.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
            shift_d    = 24'd0;
        end else if (byte_valid_i) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {byte_data_i, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'd3);
    assign word_data_o  = {byte_data_i, shift_q};

endmodule

// File: rtl/itcm_loader.sv
// rtl/itcm_loader.sv - boot loader streaming bytes into the dual-bank ITCM and holding the core in reset
// Optional trailing 32-bit checksum when ITCM_LOADER_CHECKSUM_EN is defined.
module itcm_loader
    import itcm_loader_pkg::*;
#(
    parameter  int ITCM_DEPTH = ITCM_DEPTH_DEFAULT,
    localparam int AW         = $clog2(ITCM_DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW:0]   load_len,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    output logic          bank_we,
    output logic [AW-1:0] bank_addr,
    output logic [15:0]   bank0_wdata,
    output logic [15:0]   bank1_wdata,
    output logic          core_resetn,
    output logic          done,
    output logic          error
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(ITCM_DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_e        state_q;
    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;
    logic          in_ready_q;
    logic          bank_we_q;
    logic [AW-1:0] bank_addr_q;
    logic [15:0]   bank0_q;
    logic [15:0]   bank1_q;
    logic          core_resetn_q;
    logic          done_q;
`ifdef ITCM_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q;
    logic          error_q;
`endif

    logic [AW:0]   len_d;
    logic [AW:0]   idx_d;
    logic          accept;
    logic          start_ok;
    logic          word_valid;
    logic [31:0]   word_data;

    assign len_d    = (load_len > LEN_MAX) ? LEN_MAX : load_len;
    assign idx_d    = idx_q + ONE;
    assign accept   = in_valid && in_ready_q;
    assign start_ok = start && (state_q == ST_IDLE);

    byte_to_word_packer u_packer (
        .clk_i        (clk),
        .rstn_i       (resetn),
        .clear_i      (start_ok),
        .byte_valid_i (accept),
        .byte_data_i  (in_byte),
        .word_valid_o (word_valid),
        .word_data_o  (word_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            in_ready_q    <= 1'b0;
            bank_we_q     <= 1'b0;
            bank_addr_q   <= '0;
            bank0_q       <= 16'd0;
            bank1_q       <= 16'd0;
            core_resetn_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef ITCM_LOADER_CHECKSUM_EN
            sum_q         <= 32'd0;
            error_q       <= 1'b0;
`endif
        end else begin
            bank_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= len_d;
                        idx_q <= '0;
`ifdef ITCM_LOADER_CHECKSUM_EN
                        sum_q <= 32'd0;
`endif
                        if (len_d == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q    <= ST_RECV;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    // The fourth byte is written during the following (WRITE) cycle.
                    if (word_valid) begin
                        state_q     <= ST_WRITE;
                        in_ready_q  <= 1'b0;
                        bank_we_q   <= 1'b1;
                        bank_addr_q <= idx_q[AW-1:0];
                        bank0_q     <= bank0_of(word_data);
                        bank1_q     <= bank1_of(word_data);
`ifdef ITCM_LOADER_CHECKSUM_EN
                        sum_q       <= sum_q + word_data;
`endif
                    end
                end
                ST_WRITE: begin
                    idx_q <= idx_d;
                    if (idx_d == len_q) begin
`ifdef ITCM_LOADER_CHECKSUM_EN
                        state_q    <= ST_CHECK;
                        in_ready_q <= 1'b1;
`else
                        state_q    <= ST_DONE;
`endif
                    end else begin
                        state_q    <= ST_RECV;
                        in_ready_q <= 1'b1;
                    end
                end
`ifdef ITCM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (word_valid) begin
                        error_q    <= (word_data != sum_q);
                        in_ready_q <= 1'b0;
                        state_q    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    // Core is released even on checksum error; the boot monitor reports it.
                    done_q        <= 1'b1;
                    core_resetn_q <= 1'b1;
                    in_ready_q    <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign bank_we     = bank_we_q;
    assign bank_addr   = bank_addr_q;
    assign bank0_wdata = bank0_q;
    assign bank1_wdata = bank1_q;
    assign core_resetn = core_resetn_q;
    assign done        = done_q;
`ifdef ITCM_LOADER_CHECKSUM_EN
    assign error       = error_q;
`else
    assign error       = 1'b0;
`endif

endmodule
